// File: rtl/dmem_responder.sv
// Data-memory responder for a core LSU: byte-enabled word memory behind a req/gnt handshake,
// answering every grant in order after a fixed LATENCY through a shift pipeline.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS     = 1024,
    parameter int unsigned LATENCY         = 1,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    input  logic [3:0]  data_byteen,
    input  logic        gnt_stall,
    output logic        data_gnt,
    output logic        data_valid,
    output logic [31:0] data_rdata,
    output logic        data_err
);

    localparam int unsigned AddrW  = $clog2(DEPTH_WORDS);
    localparam int          Lat    = int'(LATENCY);
    localparam logic [2:0]  MaxOut = 3'(MAX_OUTSTANDING);

    logic [31:0]      mem [DEPTH_WORDS];

    logic [2:0]       pending_q;
    logic [2:0]       pending_d;
    logic [Lat-1:0]   valid_q;
    logic [Lat-1:0]   err_q;
    logic [31:0]      rdata_q [Lat];

    logic [AddrW-1:0] word_idx;
    logic             in_range;
    logic             grant;
    logic             do_write;
    logic             do_read;
    logic             unused_addr_bits;

    assign word_idx         = data_addr[AddrW+1:2];
    assign in_range         = (data_addr[31:AddrW+2] == '0);
    assign unused_addr_bits = ^data_addr[1:0];

    // reset_n gates the grant so nothing is accepted while reset is asserted.
    assign grant    = data_req & ~gnt_stall & (pending_q < MaxOut) & reset_n;
    assign data_gnt = grant;
    assign do_write = grant & data_wr & in_range;
    assign do_read  = grant & ~data_wr & in_range;

    // Memory is deliberately not reset so contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int i = 0; i < 4; i++) begin
                if (data_byteen[i]) begin
                    mem[word_idx][8*i +: 8] <= data_wdata[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        pending_d = pending_q;
        if (grant && !data_valid) begin
            pending_d = pending_q + 3'd1;
        end else if (!grant && data_valid) begin
            pending_d = pending_q - 3'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_q <= '0;
            valid_q   <= '0;
            err_q     <= '0;
            for (int i = 0; i < Lat; i++) begin
                rdata_q[i] <= '0;
            end
        end else begin
            pending_q  <= pending_d;
            valid_q[0] <= grant;
            err_q[0]   <= grant & ~in_range;
            // Non-read and idle slots carry zero data so the output is zero when not valid.
            rdata_q[0] <= do_read ? mem[word_idx] : 32'h0;
            for (int i = 1; i < Lat; i++) begin
                valid_q[i] <= valid_q[i-1];
                err_q[i]   <= err_q[i-1];
                rdata_q[i] <= rdata_q[i-1];
            end
        end
    end

    assign data_valid = valid_q[Lat-1];
    assign data_err   = err_q[Lat-1];
    assign data_rdata = rdata_q[Lat-1];

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances (LATENCY 1, 3 and 2) with
// hand-computed grant/valid/data expectations.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req   [3];
    logic        wr    [3];
    logic        stall [3];
    logic [31:0] addr  [3];
    logic [31:0] wdata [3];
    logic [3:0]  be    [3];
    wire         gnt   [3];
    wire         vld   [3];
    wire         err   [3];
    wire  [31:0] rdata [3];

    int total = 0;
    int bad   = 0;

    // Expected per-cycle grant/valid for 6 held reads at LATENCY=3, MAX_OUTSTANDING=2.
    bit exp_g [14] = '{1, 1, 0, 0, 1, 1, 0, 0, 1, 1, 0, 0, 0, 0};
    bit exp_v [14] = '{0, 0, 0, 1, 1, 0, 0, 1, 1, 0, 0, 1, 1, 0};

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(1), .MAX_OUTSTANDING(2)) u_lat1 (
        .clk(clk), .reset_n(reset_n), .data_req(req[0]), .data_wr(wr[0]),
        .data_addr(addr[0]), .data_wdata(wdata[0]), .data_byteen(be[0]),
        .gnt_stall(stall[0]), .data_gnt(gnt[0]), .data_valid(vld[0]),
        .data_rdata(rdata[0]), .data_err(err[0])
    );

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(3), .MAX_OUTSTANDING(2)) u_lat3 (
        .clk(clk), .reset_n(reset_n), .data_req(req[1]), .data_wr(wr[1]),
        .data_addr(addr[1]), .data_wdata(wdata[1]), .data_byteen(be[1]),
        .gnt_stall(stall[1]), .data_gnt(gnt[1]), .data_valid(vld[1]),
        .data_rdata(rdata[1]), .data_err(err[1])
    );

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2), .MAX_OUTSTANDING(2)) u_lat2 (
        .clk(clk), .reset_n(reset_n), .data_req(req[2]), .data_wr(wr[2]),
        .data_addr(addr[2]), .data_wdata(wdata[2]), .data_byteen(be[2]),
        .gnt_stall(stall[2]), .data_gnt(gnt[2]), .data_valid(vld[2]),
        .data_rdata(rdata[2]), .data_err(err[2])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // One complete transaction on instance k; called just after a rising edge.
    task automatic xact(input int k, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] b,
                        output logic [31:0] rd, output logic e, output int gw, output int lat);
        req[k] = 1'b1; wr[k] = w; addr[k] = a; wdata[k] = d; be[k] = b;
        gw = 0;
        do begin
            @(negedge clk);
            gw++;
        end while (!gnt[k] && gw < 20);
        check("gnt_wait", gnt[k], 1);
        @(posedge clk); #1;
        req[k] = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!vld[k] && lat < 10);
        check("vld_wait", vld[k], 1);
        rd = rdata[k];
        e  = err[k];
        @(posedge clk); #1;
    endtask

    task automatic wr_word(input int k, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] b, input logic exp_err, input int exp_lat,
                           input string tag);
        logic [31:0] rd;
        logic        e;
        int          gw;
        int          lat;
        xact(k, 1'b1, a, d, b, rd, e, gw, lat);
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_rdata"}, rd, 32'h0);
        check({tag, "_err"}, e, exp_err);
    endtask

    task automatic rd_word(input int k, input logic [31:0] a, input logic [31:0] exp_d,
                           input logic exp_err, input int exp_lat, input string tag);
        logic [31:0] rd;
        logic        e;
        int          gw;
        int          lat;
        xact(k, 1'b0, a, 32'h0, 4'h0, rd, e, gw, lat);
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_rdata"}, rd, exp_d);
        check({tag, "_err"}, e, exp_err);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        e;
        int          gw;
        int          lat;
        int          ng;

        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            req[k] = 1'b0; wr[k] = 1'b0; stall[k] = 1'b0;
            addr[k] = 32'h0; wdata[k] = 32'h0; be[k] = 4'h0;
        end
        #1 reset_n = 1'b0;
        req[0] = 1'b1;

        // Reset state with a request pending: nothing granted, outputs zero.
        @(negedge clk);
        @(negedge clk);
        check("rst_gnt", gnt[0], 0);
        check("rst_vld", vld[0], 0);
        check("rst_rdata", rdata[0], 32'h0);
        check("rst_err", err[0], 0);
        check("rst_vld_l3", vld[1], 0);

        @(posedge clk); #1;
        reset_n = 1'b1;

        // First grant in the first cycle out of reset, then the basic write/read pair.
        xact(0, 1'b1, 32'h40, 32'hDEADBEEF, 4'hF, rd, e, gw, lat);
        check("first_gnt_cycle", gw, 1);
        check("wr40_lat", lat, 1);
        check("wr40_rdata", rd, 32'h0);
        check("wr40_err", e, 0);
        rd_word(0, 32'h40, 32'hDEADBEEF, 1'b0, 1, "rd40");

        // Byte enables.
        wr_word(0, 32'h80, 32'h11223344, 4'hF, 1'b0, 1, "wr80_full");
        wr_word(0, 32'h80, 32'hAABBCCDD, 4'h5, 1'b0, 1, "wr80_part");
        rd_word(0, 32'h80, 32'h11BB33DD, 1'b0, 1, "rd80_part");
        wr_word(0, 32'h80, 32'hFFFFFFFF, 4'h0, 1'b0, 1, "wr80_be0");
        rd_word(0, 32'h80, 32'h11BB33DD, 1'b0, 1, "rd80_be0");

        // Range boundaries and out-of-range accesses.
        wr_word(0, 32'h0, 32'hCAFEF00D, 4'hF, 1'b0, 1, "wr0");
        wr_word(0, 32'hFFC, 32'h76543210, 4'hF, 1'b0, 1, "wr_last");
        rd_word(0, 32'hFFC, 32'h76543210, 1'b0, 1, "rd_last");
        rd_word(0, 32'h1000, 32'h0, 1'b1, 1, "oor_rd");
        wr_word(0, 32'h1000, 32'h12345678, 4'hF, 1'b1, 1, "oor_wr");
        wr_word(0, 32'hFFFFFFC0, 32'h12345678, 4'hF, 1'b1, 1, "oor_wr_hi");
        rd_word(0, 32'h0, 32'hCAFEF00D, 1'b0, 1, "oor_alias0");
        rd_word(0, 32'h40, 32'hDEADBEEF, 1'b0, 1, "oor_alias40");

        // Read granted the cycle after a write to the same word sees the new data.
        req[0] = 1'b1; wr[0] = 1'b1; addr[0] = 32'h44; wdata[0] = 32'h0BADF00D; be[0] = 4'hF;
        @(negedge clk);
        check("raw_gnt_w", gnt[0], 1);
        @(posedge clk); #1;
        wr[0] = 1'b0;
        @(negedge clk);
        check("raw_gnt_r", gnt[0], 1);
        check("raw_vld_w", vld[0], 1);
        check("raw_rdata_w", rdata[0], 32'h0);
        @(posedge clk); #1;
        req[0] = 1'b0;
        @(negedge clk);
        check("raw_vld_r", vld[0], 1);
        check("raw_rdata_r", rdata[0], 32'h0BADF00D);
        @(negedge clk);
        check("idle_vld", vld[0], 0);
        check("idle_rdata", rdata[0], 32'h0);
        check("idle_err", err[0], 0);
        @(posedge clk); #1;

        // LATENCY=3, MAX_OUTSTANDING=2: held reads.
        wr_word(1, 32'h10, 32'h55AA55AA, 4'hF, 1'b0, 3, "l3_wr");
        req[1] = 1'b1; wr[1] = 1'b0; addr[1] = 32'h10;
        ng = 0;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            check($sformatf("l3_gnt_c%0d", c), gnt[1], exp_g[c]);
            check($sformatf("l3_vld_c%0d", c), vld[1], exp_v[c]);
            if (exp_v[c]) check($sformatf("l3_rdata_c%0d", c), rdata[1], 32'h55AA55AA);
            if (gnt[1]) ng++;
            @(posedge clk); #1;
            if (ng >= 6) req[1] = 1'b0;
        end

        // Stall: one read in flight, then 5 stalled cycles with the request held.
        req[1] = 1'b1;
        @(negedge clk);
        check("stall_pre_gnt", gnt[1], 1);
        @(posedge clk); #1;
        stall[1] = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            check($sformatf("stall_gnt_c%0d", c), gnt[1], 0);
            check($sformatf("stall_vld_c%0d", c), vld[1], c == 3);
            if (c == 3) check("stall_rdata", rdata[1], 32'h55AA55AA);
            @(posedge clk); #1;
        end
        stall[1] = 1'b0;
        @(negedge clk);
        check("stall_release_gnt", gnt[1], 1);
        @(posedge clk); #1;
        req[1] = 1'b0;
        for (int c = 7; c <= 9; c++) begin
            @(negedge clk);
            check($sformatf("stall_post_vld_c%0d", c), vld[1], c == 9);
            if (c == 9) check("stall_post_rdata", rdata[1], 32'h55AA55AA);
            @(posedge clk); #1;
        end

        // LATENCY=2: reset pulse one cycle after a read grant flushes the response.
        wr_word(2, 32'h20, 32'h13579BDF, 4'hF, 1'b0, 2, "l2_wr");
        req[2] = 1'b1; wr[2] = 1'b0; addr[2] = 32'h20;
        @(negedge clk);
        check("rstmid_gnt", gnt[2], 1);
        @(posedge clk); #1;
        req[2] = 1'b0;
        reset_n = 1'b0;
        #1;
        check("rstmid_async_vld", vld[2], 0);
        check("rstmid_async_gnt", gnt[2], 0);
        #1 reset_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check($sformatf("rstmid_vld_c%0d", c), vld[2], 0);
            @(posedge clk); #1;
        end

        // Pending cleared by reset: two back-to-back grants, memory kept.
        req[2] = 1'b1;
        @(negedge clk);
        check("post_rst_gnt0", gnt[2], 1);
        @(posedge clk); #1;
        @(negedge clk);
        check("post_rst_gnt1", gnt[2], 1);
        @(posedge clk); #1;
        req[2] = 1'b0;
        @(negedge clk);
        check("post_rst_vld0", vld[2], 1);
        check("post_rst_rdata0", rdata[2], 32'h13579BDF);
        @(negedge clk);
        check("post_rst_vld1", vld[2], 1);
        check("post_rst_rdata1", rdata[2], 32'h13579BDF);
        @(negedge clk);
        check("post_rst_idle", vld[2], 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
